// File: rtl/sys_clkrst_gen.sv
// Clock-enable and reset sequencer for the 580-series machine tops.
// It produces CPU, timer, pixel, PS/2 and IO strobes, the machine reset sequence and the ROM overlay flag.
module sys_clkrst_gen #(
  parameter int unsigned CPU_DIV     = 28,
  parameter int unsigned TURBO_MAX   = 2,
  parameter int unsigned F2_OFFSET   = 2,
  parameter int unsigned PIT_PHASE   = 4,
  parameter int unsigned PIX_DIV     = 6,
  parameter int unsigned PS2_DIV     = 3571,
  parameter int unsigned INIT_CYCLES = 50000000,
  parameter int unsigned RST_STRETCH = 15
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] turbo,
  input  logic       reset_req,
  input  logic       dl_busy,
  input  logic       cpu_a15,
  output logic       clk_f1,
  output logic       clk_f2,
  output logic       clk_pit,
  output logic       clk_pix,
  output logic       clk_pix2x,
  output logic       clk_ps2,
  output logic       clk_io,
  output logic       sys_reset,
  output logic       startup,
  output logic [1:0] speed_cur
);

  localparam int unsigned CW  = $clog2(CPU_DIV + 1);
  localparam int unsigned PXW = $clog2(PIX_DIV + 1);
  localparam int unsigned PSW = $clog2(PS2_DIV + 1);
  localparam int unsigned IW  = $clog2(INIT_CYCLES + 1);
  localparam int unsigned SW  = $clog2(RST_STRETCH + 1);

  typedef enum logic [1:0] {StPowerOn, StHold, StStretch, StRun} state_e;

  logic [CW-1:0]  cpu_div;
  logic [CW-1:0]  sub_div;
  logic [CW-1:0]  period;
  logic [1:0]     turbo_clamp;
  logic [PXW-1:0] pix_div;
  logic [PSW-1:0] ps2_div;
  logic [1:0]     req_sync;
  logic [1:0]     busy_sync;
  logic           hold_req;
  state_e         state;
  logic [IW-1:0]  init_cnt;
  logic [SW-1:0]  stretch_cnt;

  always_comb begin
    period      = CW'(CPU_DIV >> speed_cur);
    turbo_clamp = (turbo > 2'(TURBO_MAX)) ? 2'(TURBO_MAX) : turbo;
    hold_req    = req_sync[1] | busy_sync[1];
  end

  // sub_div tracks cpu_div modulo the current strobe period. Every period divides CPU_DIV,
  // so both counters wrap together and a speed change at the wrap never leaves a stale phase.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_div   <= '0;
      sub_div   <= '0;
      speed_cur <= '0;
      pix_div   <= '0;
      ps2_div   <= '0;
      clk_f1    <= 1'b0;
      clk_f2    <= 1'b0;
      clk_pit   <= 1'b0;
      clk_pix   <= 1'b0;
      clk_pix2x <= 1'b0;
      clk_ps2   <= 1'b0;
      clk_io    <= 1'b0;
    end else begin
      if (cpu_div == CW'(CPU_DIV - 1)) begin
        cpu_div   <= '0;
        sub_div   <= '0;
        speed_cur <= turbo_clamp;
      end else begin
        cpu_div <= cpu_div + CW'(1);
        sub_div <= (sub_div == period - CW'(1)) ? '0 : sub_div + CW'(1);
      end
      pix_div   <= (pix_div == PXW'(PIX_DIV - 1)) ? '0 : pix_div + PXW'(1);
      ps2_div   <= (ps2_div == PSW'(PS2_DIV - 1)) ? '0 : ps2_div + PSW'(1);
      clk_f1    <= (sub_div == '0);
      clk_f2    <= (sub_div == CW'(F2_OFFSET));
      clk_pit   <= (cpu_div == CW'(PIT_PHASE));
      clk_pix   <= (pix_div == '0);
      clk_pix2x <= (pix_div == '0) || (pix_div == PXW'(PIX_DIV / 2));
      clk_ps2   <= (ps2_div == '0);
      clk_io    <= ~clk_io;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_sync  <= '0;
      busy_sync <= '0;
    end else begin
      req_sync  <= {req_sync[0], reset_req};
      busy_sync <= {busy_sync[0], dl_busy};
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= StPowerOn;
      init_cnt    <= '0;
      stretch_cnt <= '0;
      sys_reset   <= 1'b1;
      startup     <= 1'b1;
    end else begin
      startup <= sys_reset | (startup & ~cpu_a15);
      case (state)
        StPowerOn: begin
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            state <= StHold;
          end else if (!busy_sync[1]) begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
        StHold: begin
          stretch_cnt <= '0;
          if (!hold_req) begin
            state <= StStretch;
          end
        end
        StStretch: begin
          if (hold_req) begin
            state       <= StHold;
            stretch_cnt <= '0;
          end else if (stretch_cnt == SW'(RST_STRETCH - 1)) begin
            state     <= StRun;
            sys_reset <= 1'b0;
          end else begin
            stretch_cnt <= stretch_cnt + SW'(1);
          end
        end
        StRun: begin
          if (hold_req) begin
            state     <= StHold;
            sys_reset <= 1'b1;
          end
        end
        default: begin
          state     <= StPowerOn;
          sys_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_clkrst_gen.sv
// Self-checking bench for sys_clkrst_gen: arithmetic reference model checked every cycle,
// table-driven speed modes, and directed reset, download and startup sequences.
module tb_sys_clkrst_gen;

  localparam int CPU_DIV     = 28;
  localparam int TURBO_MAX   = 2;
  localparam int F2_OFFSET   = 2;
  localparam int PIT_PHASE   = 4;
  localparam int PIX_DIV     = 6;
  localparam int PS2_DIV     = 3571;
  localparam int INIT_CYCLES = 20;
  localparam int RST_STRETCH = 15;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] turbo = 2'd0;
  logic       reset_req = 1'b0;
  logic       dl_busy = 1'b0;
  logic       cpu_a15 = 1'b0;
  logic       clk_f1, clk_f2, clk_pit, clk_pix, clk_pix2x, clk_ps2, clk_io;
  logic       sys_reset, startup;
  logic [1:0] speed_cur;

  sys_clkrst_gen #(
    .CPU_DIV    (CPU_DIV),
    .TURBO_MAX  (TURBO_MAX),
    .F2_OFFSET  (F2_OFFSET),
    .PIT_PHASE  (PIT_PHASE),
    .PIX_DIV    (PIX_DIV),
    .PS2_DIV    (PS2_DIV),
    .INIT_CYCLES(INIT_CYCLES),
    .RST_STRETCH(RST_STRETCH)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .turbo    (turbo),
    .reset_req(reset_req),
    .dl_busy  (dl_busy),
    .cpu_a15  (cpu_a15),
    .clk_f1   (clk_f1),
    .clk_f2   (clk_f2),
    .clk_pit  (clk_pit),
    .clk_pix  (clk_pix),
    .clk_pix2x(clk_pix2x),
    .clk_ps2  (clk_ps2),
    .clk_io   (clk_io),
    .sys_reset(sys_reset),
    .startup  (startup),
    .speed_cur(speed_cur)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed edges since release, plus the speed and reset rules in plain arithmetic.
  int m_n, m_spd, m_nb, m_quiet;
  bit m_powered;
  bit h1r, h2r, h1b, h2b;
  bit e_f1, e_f2, e_pit, e_pix, e_pix2, e_ps2, e_io, e_rst, e_start;

  task automatic model_reset();
    m_n = 0; m_spd = 0; m_nb = 0; m_quiet = 0; m_powered = 0;
    h1r = 0; h2r = 0; h1b = 0; h2b = 0;
    e_f1 = 0; e_f2 = 0; e_pit = 0; e_pix = 0; e_pix2 = 0; e_ps2 = 0; e_io = 0;
    e_rst = 1; e_start = 1;
  endtask

  // Predicts outputs after the coming edge from the inputs currently applied.
  task automatic model_edge();
    int c, p;
    bit rs, bs;
    c = m_n % CPU_DIV;
    p = CPU_DIV >> m_spd;
    e_f1   = (c % p) == 0;
    e_f2   = (c % p) == F2_OFFSET;
    e_pit  = c == PIT_PHASE;
    e_pix  = (m_n % PIX_DIV) == 0;
    e_pix2 = e_pix || ((m_n % PIX_DIV) == PIX_DIV / 2);
    e_ps2  = (m_n % PS2_DIV) == 0;
    e_io   = ((m_n + 1) % 2) == 1;
    if (c == CPU_DIV - 1) m_spd = (int'(turbo) > TURBO_MAX) ? TURBO_MAX : int'(turbo);
    e_start = e_rst | (e_start & !cpu_a15);
    rs = h2r; bs = h2b;
    h2r = h1r; h1r = reset_req;
    h2b = h1b; h1b = dl_busy;
    if (!m_powered) begin
      if (m_nb == INIT_CYCLES - 1) begin
        m_powered = 1;
        m_quiet   = 0;
      end else if (!bs) begin
        m_nb++;
      end
    end else if (rs || bs) begin
      m_quiet = 0;
    end else if (m_quiet < 1000) begin
      m_quiet++;
    end
    // Machine runs once HOLD was entered and 1 + RST_STRETCH quiet edges followed.
    e_rst = !(m_powered && m_quiet >= RST_STRETCH + 1);
    m_n++;
  endtask

  task automatic check_all();
    chk("clk_f1", 32'(clk_f1), 32'(e_f1));
    chk("clk_f2", 32'(clk_f2), 32'(e_f2));
    chk("clk_pit", 32'(clk_pit), 32'(e_pit));
    chk("clk_pix", 32'(clk_pix), 32'(e_pix));
    chk("clk_pix2x", 32'(clk_pix2x), 32'(e_pix2));
    chk("clk_ps2", 32'(clk_ps2), 32'(e_ps2));
    chk("clk_io", 32'(clk_io), 32'(e_io));
    chk("sys_reset", 32'(sys_reset), 32'(e_rst));
    chk("startup", 32'(startup), 32'(e_start));
    chk("speed_cur", 32'(speed_cur), 32'(m_spd));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_all();
  endtask

  typedef struct {
    logic [1:0] turbo;
    int         exp_speed;
    int         exp_f1;
    int         exp_f2;
    int         exp_pit;
  } spd_vec_t;

  spd_vec_t vt[5];
  int cnt_pix, cnt_pix2, cnt_ps2, cnt_f1, cnt_f2, cnt_pit;
  int fall, rise, f1a, f1b, k, busy_left;

  initial begin
    vt[0] = '{2'd0, 0, 1, 1, 1};
    vt[1] = '{2'd2, 2, 4, 4, 1};
    vt[2] = '{2'd3, 2, 4, 4, 1};
    vt[3] = '{2'd0, 0, 1, 1, 1};
    vt[4] = '{2'd1, 1, 2, 2, 1};

    model_reset();
    repeat (3) @(negedge clk_sys);
    chk("rst_sys_reset", 32'(sys_reset), 32'd1);
    chk("rst_startup", 32'(startup), 32'd1);
    chk("rst_speed", 32'(speed_cur), 32'd0);
    chk("rst_io", 32'(clk_io), 32'd0);
    reset = 1'b0;
    check_all();

    // Idle power-on: release timing, strobe spacing and 6000-cycle strobe counts.
    cnt_pix = 0; cnt_pix2 = 0; cnt_ps2 = 0; fall = -1; f1a = -1; f1b = -1;
    for (int i = 1; i <= 6000; i++) begin
      tick();
      cnt_pix  += int'(clk_pix);
      cnt_pix2 += int'(clk_pix2x);
      cnt_ps2  += int'(clk_ps2);
      if (fall < 0 && !sys_reset) fall = i;
      if (clk_f1 && f1a < 0) f1a = i;
      else if (clk_f1 && f1b < 0) f1b = i;
    end
    chk("poweron_fall_edge", 32'(fall), 32'd36);
    chk("first_f1_edge", 32'(f1a), 32'd1);
    chk("f1_spacing", 32'(f1b - f1a), 32'd28);
    chk("pix_count", 32'(cnt_pix), 32'd1000);
    chk("pix2x_count", 32'(cnt_pix2), 32'd2000);
    chk("ps2_count", 32'(cnt_ps2), 32'd2);

    // Startup overlay: holds while a15 stays low, clears on first a15, returns with reset.
    repeat (100) tick();
    chk("startup_hold", 32'(startup), 32'd1);
    cpu_a15 = 1'b1;
    tick();
    chk("startup_clear", 32'(startup), 32'd0);
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    rise = -1;
    for (int t = 2; t <= 10 && rise < 0; t++) begin
      tick();
      if (sys_reset) rise = t;
    end
    chk("req_rise_ticks", 32'(rise), 32'd3);
    tick();
    chk("startup_reassert", 32'(startup), 32'd1);
    cpu_a15 = 1'b0;
    repeat (40) tick();
    chk("back_in_run", 32'(sys_reset), 32'd0);

    // Single pulse in RUN, then a second pulse landing inside STRETCH.
    for (int pass = 0; pass < 2; pass++) begin
      rise = -1; fall = -1;
      for (int t = 1; t <= 60; t++) begin
        reset_req = (t == 1) || (pass == 1 && t == 9);
        tick();
        if (rise < 0 && sys_reset) rise = t;
        if (rise >= 0 && fall < 0 && !sys_reset) fall = t;
      end
      reset_req = 1'b0;
      chk("pulse_rise", 32'(rise), 32'd3);
      chk("pulse_fall", 32'(fall), (pass == 0) ? 32'd19 : 32'd27);
    end

    // Speed modes: changes take effect only at the period wrap.
    foreach (vt[i]) begin
      repeat ($urandom_range(0, 27)) tick();
      turbo = vt[i].turbo;
      tick();
      k = 0;
      while ((m_n % CPU_DIV) != 0 && k < 2 * CPU_DIV) begin
        tick();
        k++;
      end
      chk("wrap_found", 32'((m_n % CPU_DIV) == 0), 32'd1);
      cnt_f1 = 0; cnt_f2 = 0; cnt_pit = 0;
      repeat (CPU_DIV) begin
        tick();
        cnt_f1  += int'(clk_f1);
        cnt_f2  += int'(clk_f2);
        cnt_pit += int'(clk_pit);
      end
      chk("vec_speed", 32'(speed_cur), 32'(vt[i].exp_speed));
      chk("vec_f1_count", 32'(cnt_f1), 32'(vt[i].exp_f1));
      chk("vec_f2_count", 32'(cnt_f2), 32'(vt[i].exp_f2));
      chk("vec_pit_count", 32'(cnt_pit), 32'(vt[i].exp_pit));
    end

    // Asynchronous reset between edges returns everything to reset values at once.
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_sys_reset", 32'(sys_reset), 32'd1);
    chk("async_startup", 32'(startup), 32'd1);
    chk("async_speed", 32'(speed_cur), 32'd0);
    chk("async_io", 32'(clk_io), 32'd0);
    chk("async_f1", 32'(clk_f1), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    check_all();

    // Download during power-on freezes the init count.
    fall = -1;
    for (int t = 1; t <= 120; t++) begin
      dl_busy = (t >= 11) && (t <= 40);
      tick();
      if (fall < 0 && !sys_reset) fall = t;
    end
    dl_busy = 1'b0;
    chk("busy_fall_edge", 32'(fall), 32'd66);

    // Randomised run against the model.
    busy_left = 0;
    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(0, 49) == 0) turbo = 2'($urandom_range(0, 3));
      reset_req = ($urandom_range(0, 199) == 0);
      if (busy_left > 0) busy_left--;
      else if ($urandom_range(0, 399) == 0) busy_left = $urandom_range(1, 40);
      dl_busy = (busy_left > 0);
      cpu_a15 = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
